// File: rtl/nibble_serial_accumulator_pkg.sv
// Shared types and constants for the nibble-serial accumulator.
// The state type is shared so the datapath and any observers agree on the encoding.
package nibble_serial_accumulator_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAddLo,
    StAddHi,
    StDone
  } state_e;

endpackage

// File: rtl/nibble_serial_accumulator_binary_adder.sv
// 4-bit ripple-carry adder; sum[NIBBLE_W] is the carry out.
module nibble_serial_accumulator_binary_adder
  import nibble_serial_accumulator_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic [NIBBLE_W:0]   sum
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c   = '0;
    sum = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    sum[NIBBLE_W] = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_accumulator.sv
// Sums N_OPS 4-bit operands into a NIBBLES-wide accumulator, one nibble per clock,
// reusing a single 4-bit adder; result handed off over valid/ready with a sticky overflow flag.
module nibble_serial_accumulator
  import nibble_serial_accumulator_pkg::*;
#(
  parameter int unsigned NIBBLES = 2,
  parameter int unsigned N_OPS   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic [NIBBLE_W-1:0]          in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  out_sum,
  output logic                         out_ovf,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned ACC_W   = NIBBLE_W * NIBBLES;
  localparam logic [1:0]  TopIdx  = 2'(NIBBLES - 1);
  localparam logic [7:0]  LastCnt = 8'(N_OPS - 1);

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [7:0]            op_cnt_q, op_cnt_d;
  logic [1:0]            nib_idx_q, nib_idx_d;
  logic                  carry_q, carry_d;
  logic                  ovf_q, ovf_d;
  logic [NIBBLE_W-1:0]   opnd_q, opnd_d;

  logic [NIBBLE_W-1:0]   cur_nib;
  logic [NIBBLE_W-1:0]   add_a, add_b;
  logic [NIBBLE_W:0]     add_sum;

  // Accumulator nibble addressed by nib_idx.
  always_comb begin
    cur_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (nib_idx_q == 2'(i)) begin
        cur_nib = acc_q[NIBBLE_W*i +: NIBBLE_W];
      end
    end
  end

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_q)
      StAddLo: begin
        add_a = acc_q[NIBBLE_W-1:0];
        add_b = opnd_q;
      end
      StAddHi: begin
        add_a = cur_nib;
        add_b = {{(NIBBLE_W-1){1'b0}}, carry_q};
      end
      default: ;
    endcase
  end

  nibble_serial_accumulator_binary_adder u_binary_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_cnt_d  = op_cnt_q;
    nib_idx_d = nib_idx_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    opnd_d    = opnd_q;

    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          opnd_d  = in_data;
          state_d = StAddLo;
        end
      end
      StAddLo: begin
        acc_d[NIBBLE_W-1:0] = add_sum[NIBBLE_W-1:0];
        carry_d             = add_sum[NIBBLE_W];
        nib_idx_d           = 2'd1;
        state_d             = StAddHi;
      end
      StAddHi: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (nib_idx_q == 2'(i)) begin
            acc_d[NIBBLE_W*i +: NIBBLE_W] = add_sum[NIBBLE_W-1:0];
          end
        end
        carry_d = add_sum[NIBBLE_W];
        // Every nibble is walked even when the carry dies early, keeping timing fixed.
        if (nib_idx_q == TopIdx) begin
          ovf_d     = ovf_q | add_sum[NIBBLE_W];
          op_cnt_d  = op_cnt_q + 8'd1;
          nib_idx_d = 2'd0;
          state_d   = (op_cnt_q == LastCnt) ? StDone : StIdle;
        end else begin
          nib_idx_d = nib_idx_q + 2'd1;
        end
      end
      StDone: begin
        if (out_valid && out_ready) begin
          acc_d    = '0;
          op_cnt_d = '0;
          ovf_d    = 1'b0;
          carry_d  = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Batch abort outranks any handshake in the same cycle.
    if (clr) begin
      state_d   = StIdle;
      acc_d     = '0;
      op_cnt_d  = '0;
      nib_idx_d = '0;
      carry_d   = 1'b0;
      ovf_d     = 1'b0;
      opnd_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      op_cnt_q  <= '0;
      nib_idx_q <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      opnd_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_cnt_q  <= op_cnt_d;
      nib_idx_q <= nib_idx_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      opnd_q    <= opnd_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid & ovf_q;

endmodule
